octal_decoder_seq: RTL and testbench

Sequenced 3-to-8 binary-to-octal decoder. It is the inverse of the team's octal-to-binary encoder. It accepts a 3-bit code over a valid/ready handshake and drives the matching one-hot output line for a programmable number of cycles, followed by an all-zero gap. A sweep mode walks all eight lines in order, 0 to 7. It drives one-hot select/strobe lines and provides the stimulus source for the encoder's loopback test.

---
 rtl/octal_decoder_seq_if.sv | 22 ++
 rtl/octal_decoder_seq.sv | 111 +++++++++++
 tb/tb_octal_decoder_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/octal_decoder_seq_if.sv
// Handshake and output bundle for the sequenced 3-to-8 decoder.
// master drives codes and sweep requests; slave is the decoder itself.
interface octal_decoder_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in;
  logic       sweep_start;
  logic [7:0] out;
  logic       out_valid;
  logic       busy;
  logic       done;

  modport master (
    output in_valid, in, sweep_start,
    input  in_ready, out, out_valid, busy, done
  );

  modport slave (
    input  in_valid, in, sweep_start,
    output in_ready, out, out_valid, busy, done
  );
endinterface

// File: rtl/octal_decoder_seq.sv
// Sequenced 3-to-8 decoder: drives a one-hot line for HOLD cycles followed by GAP zero
// cycles, either for one handshaked code or as a 0..7 sweep.
module octal_decoder_seq #(
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 1
) (
  input logic                clk,
  input logic                rst_n,
  octal_decoder_seq_if.slave dec
);

  localparam int unsigned MaxCnt = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned CntW   = (MaxCnt > 0) ? $clog2(MaxCnt + 1) : 1;
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD - 1);
  localparam logic [CntW-1:0] GapLast  = (GAP > 0) ? CntW'(GAP - 1) : '0;

  typedef enum logic [1:0] {StIdle, StDrive, StGap} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      code_q, code_d;
  logic            sweep_q, sweep_d;
  logic [7:0]      out_q, out_d;
  logic            done_q, done_d;
  logic            post_gap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      code_q  <= '0;
      sweep_q <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      sweep_q <= sweep_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    sweep_d  = sweep_q;
    out_d    = out_q;
    done_d   = 1'b0;
    post_gap = 1'b0;

    unique case (state_q)
      StIdle: begin
        // sweep_start wins; in_ready is low in that cycle so no code is consumed
        if (dec.sweep_start) begin
          sweep_d = 1'b1;
          code_d  = 3'd0;
          out_d   = 8'd1;
          cnt_d   = HoldLast;
          state_d = StDrive;
        end else if (dec.in_valid) begin
          code_d  = dec.in;
          out_d   = 8'd1 << dec.in;
          cnt_d   = HoldLast;
          state_d = StDrive;
        end
      end
      StDrive: begin
        if (cnt_q == '0) begin
          out_d = '0;
          if (GAP > 0) begin
            cnt_d   = GapLast;
            state_d = StGap;
          end else begin
            post_gap = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == '0) post_gap = 1'b1;
        else             cnt_d = cnt_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (post_gap) begin
      if (sweep_q && (code_q != 3'd7)) begin
        code_d  = code_q + 3'd1;
        out_d   = 8'd1 << (code_q + 3'd1);
        cnt_d   = HoldLast;
        state_d = StDrive;
      end else begin
        sweep_d = 1'b0;
        out_d   = '0;
        done_d  = 1'b1;
        state_d = StIdle;
      end
    end
  end

  assign dec.in_ready  = (state_q == StIdle) && !dec.sweep_start;
  assign dec.out       = out_q;
  assign dec.out_valid = |out_q;
  assign dec.busy      = (state_q != StIdle);
  assign dec.done      = done_q;

endmodule

// File: tb/tb_octal_decoder_seq.sv
// Bench for octal_decoder_seq: a per-cycle expected-output schedule is built from each
// accepted request and compared cycle by cycle against the decoder.
module tb_octal_decoder_seq;
  localparam int unsigned HOLD = 2;
  localparam int unsigned GAP  = 1;

  typedef struct packed {
    logic [7:0] out;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  exp_t pend[$];
  exp_t cur;
  exp_t idle_e;

  octal_decoder_seq_if bus ();

  octal_decoder_seq #(
    .HOLD (HOLD),
    .GAP  (GAP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dec   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected timeline: HOLD one-hot cycles then GAP zero cycles per code, then a done cycle
  task automatic model_accept(input logic sweep, input logic [2:0] code);
    exp_t e;
    int   first;
    int   last;
    first = sweep ? 0 : int'(code);
    last  = sweep ? 7 : int'(code);
    for (int c = first; c <= last; c++) begin
      for (int h = 0; h < HOLD; h++) begin
        e.out  = 8'd1 << c;
        e.busy = 1'b1;
        e.done = 1'b0;
        pend.push_back(e);
      end
      for (int g = 0; g < GAP; g++) begin
        e.out  = 8'd0;
        e.busy = 1'b1;
        e.done = 1'b0;
        pend.push_back(e);
      end
    end
    e.out  = 8'd0;
    e.busy = 1'b0;
    e.done = 1'b1;
    pend.push_back(e);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out"},       bus.out,       cur.out);
    check({tag, ".out_valid"}, bus.out_valid, cur.out != 8'd0);
    check({tag, ".busy"},      bus.busy,      cur.busy);
    check({tag, ".done"},      bus.done,      cur.done);
    check({tag, ".onehot"},    $countones(bus.out) <= 1, 1'b1);
  endtask

  task automatic step(input string tag, input logic v, input logic [2:0] c, input logic s);
    bus.in_valid    = v;
    bus.in          = c;
    bus.sweep_start = s;
    #1;
    check({tag, ".in_ready"}, bus.in_ready, !cur.busy && !s);
    if (!cur.busy && s)      model_accept(1'b1, 3'd0);
    else if (!cur.busy && v) model_accept(1'b0, c);
    @(posedge clk);
    #1;
    cur = (pend.size() > 0) ? pend.pop_front() : idle_e;
    check_outputs(tag);
  endtask

  task automatic idle_steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    logic found;
    vectors         = 0;
    miscompares     = 0;
    idle_e          = '0;
    cur             = idle_e;
    bus.in_valid    = 1'b0;
    bus.in          = 3'd0;
    bus.sweep_start = 1'b0;
    rst_n           = 1'b1;

    // Reset asserted between edges must clear outputs without a clock edge
    #2 rst_n = 1'b0;
    #1 check_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("reset.in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Single code 5
    step("single5", 1'b1, 3'd5, 1'b0);
    idle_steps("single5", 5);

    // Full sweep
    step("sweep", 1'b0, 3'd0, 1'b1);
    idle_steps("sweep", 26);

    // Busy rejection: code 2 held valid while code 6 runs, taken on the done cycle
    step("busy6", 1'b1, 3'd6, 1'b0);
    for (int i = 0; i < 4; i++) step("busy2", 1'b1, 3'd2, 1'b0);
    idle_steps("busy2", 5);

    // sweep_start beats in_valid on the same edge
    step("prio", 1'b1, 3'd3, 1'b1);
    idle_steps("prio", 26);

    // Reset mid-sweep while code 4 drives
    step("rstsweep", 1'b0, 3'd0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (cur.out == 8'h10) found = 1'b1;
      else step("rstsweep", 1'b0, 3'd0, 1'b0);
    end
    check("rstsweep.reached4", found, 1'b1);
    rst_n = 1'b0;
    pend.delete();
    cur = idle_e;
    #1 check_outputs("rstmid");
    #1 rst_n = 1'b1;
    step("after_rst7", 1'b1, 3'd7, 1'b0);
    idle_steps("after_rst7", 4);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 15) == 0));
    end
    idle_steps("drain", 30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
